// File: rtl/ble_packet_sequencer_pkg.sv
// Shared types and constants for the BLE packet sequencer.
// FSM encodings, whitening polynomial/seed, default widths.
package ble_packet_sequencer_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int REP_W_DEF  = 4;
   localparam int GAP_W_DEF  = 8;

   localparam int             WHT_W        = 7;
   // x^7 + x^4 + 1: feedback into bit 0 and bit 4
   localparam logic [WHT_W-1:0] WHT_POLY   = 7'b001_0001;
   localparam logic           WHT_SEED_MSB = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEAD = 3'd1,
      S_TX   = 3'd2,
      S_GAP  = 3'd3,
      S_TAIL = 3'd4,
      S_DONE = 3'd5
   } state_t;

   function automatic logic [WHT_W-1:0] wht_seed(input logic [5:0] chan);
      return {WHT_SEED_MSB, chan};
   endfunction

endpackage

// File: rtl/ble_packet_sequencer_whitener.sv
// ble_whitener: 7-bit x^7+x^4+1 LFSR, output tap bit 6.
// Used by ble_packet_sequencer only when BLE_WHITENING_EN is defined.
module ble_whitener
   import ble_packet_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WHT_W-1:0] i_seed,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic             i_bit,
   output logic             o_bit
);

   logic [WHT_W-1:0] r_lfsr;
   logic [WHT_W-1:0] w_fb;

   assign w_fb = r_lfsr[WHT_W-1] ? WHT_POLY : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_lfsr <= '0;
      else if (i_load)
         r_lfsr <= i_seed;
      else if (i_shift)
         r_lfsr <= {r_lfsr[WHT_W-2:0], 1'b0} ^ w_fb;
   end

   assign o_bit = i_bit ^ r_lfsr[WHT_W-1];

endmodule

// File: rtl/ble_packet_sequencer.sv
// BLE packet sequencer: streams ROM symbols to the FSK modulator with repeats/gap/abort.
// Optional whitening via `define BLE_WHITENING_EN.
module ble_packet_sequencer
   import ble_packet_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int REP_W  = REP_W_DEF,
   parameter int GAP_W  = GAP_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              trig,
   input  logic              abort,
   input  logic [ADDR_W-1:0] pkt_len,
   input  logic [REP_W-1:0]  rep_cnt,
   input  logic [GAP_W-1:0]  gap_len,
   input  logic [5:0]        chan_idx,
   input  logic              symDone,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_data,
   output logic              start,
   output logic              symVal,
   output logic              busy,
   output logic              done
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_len;
   logic [REP_W-1:0]  r_reps;
   logic [GAP_W-1:0]  r_gap_len;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic              r_hold;
   logic              r_sym;

   logic w_go;
   logic w_last;
   logic w_gap_last;
   logic w_live;
   logic w_adv;
   logic w_data;
   logic w_next_sym;

   assign w_go       = trig && (pkt_len != '0);
   assign w_last     = (r_addr == r_len - ADDR_W'(1));
   assign w_gap_last = (r_gap_len == '0) ||
                       (r_gap_cnt == r_gap_len - GAP_W'(1));
   assign w_live     = (r_state == S_LEAD) || (r_state == S_TX);
   assign w_adv      = (r_state == S_TX) && symDone && !abort;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (w_go) w_state_nxt = S_LEAD;
         S_LEAD: w_state_nxt = abort ? S_TAIL : S_TX;
         S_TX: begin
            if (abort)
               w_state_nxt = S_TAIL;
            else if (symDone && w_last)
               w_state_nxt = (r_reps != '0) ? S_GAP : S_TAIL;
         end
         S_GAP: begin
            if (abort)
               w_state_nxt = S_TAIL;
            else if (w_gap_last)
               w_state_nxt = S_LEAD;
         end
         S_TAIL: w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_len     <= '0;
         r_reps    <= '0;
         r_gap_len <= '0;
         r_gap_cnt <= '0;
         r_hold    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_go) begin
            r_len     <= pkt_len;
            r_reps    <= rep_cnt;
            r_gap_len <= gap_len;
            r_addr    <= '0;
         end
         // last index holds into TAIL; rewinds only when another packet follows
         if (w_adv && !w_last)
            r_addr <= r_addr + ADDR_W'(1);
         else if (w_adv && r_reps != '0)
            r_addr <= '0;
         r_gap_cnt <= (r_state == S_GAP && !w_gap_last) ?
                      r_gap_cnt + GAP_W'(1) : '0;
         if (r_state == S_GAP && !abort && w_gap_last)
            r_reps <= r_reps - REP_W'(1);
         if (w_live)
            r_hold <= w_data;
      end
   end

`ifdef BLE_WHITENING_EN
   logic [5:0]       r_chan;
   logic             w_load;
   logic [WHT_W-1:0] w_seed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_chan <= '0;
      else if (r_state == S_IDLE && w_go)
         r_chan <= chan_idx;
   end

   // seed on entry to LEAD so the first symbol is already whitened
   assign w_load = (r_state == S_IDLE && w_go) ||
                   (r_state == S_GAP && !abort && w_gap_last);
   assign w_seed = wht_seed((r_state == S_IDLE) ? chan_idx : r_chan);

   ble_whitener u_whitener (
      .clk     (clk),
      .rst     (rst),
      .i_seed  (w_seed),
      .i_load  (w_load),
      .i_shift (w_adv),
      .i_bit   (rom_data),
      .o_bit   (w_data)
   );
`else
   assign w_data = rom_data;
`endif

   assign w_next_sym = w_live ? w_data : r_hold;

   always_ff @(negedge clk or posedge rst) begin
      if (rst)
         r_sym <= 1'b0;
      else
         r_sym <= ~w_next_sym;
   end

   assign rom_addr = r_addr;
   assign symVal   = r_sym;
   assign start    = (r_state == S_LEAD) || (r_state == S_TX) ||
                     (r_state == S_TAIL);
   assign busy     = (r_state == S_LEAD) || (r_state == S_TX) ||
                     (r_state == S_GAP)  || (r_state == S_TAIL);
   assign done     = (r_state == S_DONE);

endmodule
